xenoa_history_tracker: RTL and testbench
========================================

XENOA_HISTORY_TRACKER -- requirements
Module: xenoa_history_tracker

Interface
REQ-001 SHALL have parameter MIN_VALID, default 4, meaning the fill count at or above which history_valid asserts (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning a synchronous active-high reset.
REQ-004 SHALL have port sample_value, input, 32, meaning an unsigned contract-bound value to record.
REQ-005 SHALL have port sample_valid, input, 1, meaning sample_value is presented this cycle.
REQ-006 SHALL have port hist_clear, input, 1, meaning empty the history.
REQ-007 SHALL have port hist_freeze, input, 1, meaning hold contents and drop incoming samples.
REQ-008 SHALL have port history_buffer[0:15], output, 16x32, meaning stored samples, [0] newest.
REQ-009 SHALL have port history_valid, output, 1, meaning fill_count >= MIN_VALID.
REQ-010 SHALL have port fill_count, output, 5, meaning number of stored samples (0..16).
REQ-011 SHALL have port window_sum, output, 36, meaning the unsigned sum of all stored samples.
REQ-012 SHALL have port drop_count, output, 8, meaning a saturating count of samples dropped while frozen.
REQ-013 SHALL have port hist_state, output, 2, meaning the FSM state encoding.

Function
REQ-014 SHALL implement FSM states EMPTY=0, FILL=1, FULL=2 and FROZEN=3.
REQ-015 SHALL, in EMPTY or FILL with an accepted push, go to FILL when the new fill_count is below 16 and to FULL when it reaches 16.
REQ-016 SHALL stay in FULL on a push.
REQ-017 SHALL, with hist_freeze=1 and hist_clear=0, go from any state to FROZEN.
REQ-018 SHALL, in FROZEN with hist_freeze=0, return to EMPTY, FILL or FULL according to the current fill_count (0, 1..15, 16).
REQ-019 SHALL accept a push when sample_valid=1, hist_clear=0, hist_freeze=0 and the state is not FROZEN.
REQ-020 SHALL, on an accepted push, shift history_buffer[i] into history_buffer[i+1] for i=0..14, discard the old [15], and load sample_value into [0], all in the same edge.
REQ-021 SHALL, on an accepted push, increment fill_count and saturate it at 16.
REQ-022 SHALL, on an accepted push, set window_sum to window_sum + sample_value - old history_buffer[15], using 36-bit unsigned arithmetic.
REQ-023 SHALL hold unused slots (index >= fill_count) at zero at all times, so the old [15] term is 0 while not FULL.
REQ-024 SHALL make every output registered with one-cycle latency: a sample pushed at edge N is visible on history_buffer[0] after edge N.
REQ-025 SHALL let a downstream consumer that samples sample_value on the same edge as a push see the previous sample in history_buffer[0], giving the current-minus-previous trend.
REQ-026 SHALL keep history_valid a registered copy of (next fill_count >= MIN_VALID) that updates in the same cycle as fill_count, and SHALL hold it while FROZEN.
REQ-027 SHALL, on hist_clear=1, zero all slots, fill_count, window_sum and drop_count and enter EMPTY next cycle; hist_clear has priority over hist_freeze and sample_valid, and the sample is discarded and not counted as dropped.
REQ-028 SHALL increment drop_count, saturating at 255, when sample_valid=1 while hist_freeze=1 or the state is FROZEN, with hist_clear=0.
REQ-029 SHALL hold history_buffer, fill_count and window_sum unchanged while FROZEN.
REQ-030 SHALL leave all state unchanged when sample_valid=0 and no clear is applied.

Reset
REQ-031 SHALL, while rst=1 at a clk edge, set history_buffer to all 0, fill_count=0, window_sum=0, drop_count=0, history_valid=0 and hist_state=EMPTY.
REQ-032 SHALL make reset take priority over every other input and abandon any in-progress fill, with no sample retained.
REQ-033 SHALL leave the first post-reset push landing in history_buffer[0] with fill_count=1.

Verification
REQ-034 SHALL cover push 1,2,3,4 at MIN_VALID=4 -> history_buffer[0..3]=4,3,2,1, fill_count=4, window_sum=10, history_valid rising on the cycle after the 4th push.
REQ-035 SHALL cover push 1..17 -> FULL, [0]=17, [15]=2, fill_count=16, window_sum=152.
REQ-036 SHALL cover 16 pushes of 0xFFFFFFFF -> window_sum=0xFFFFFFFF0 with no overflow, and a 17th push of 0 -> window_sum=0xEFFFFFFF1.
REQ-037 SHALL cover hist_freeze with 300 pushes -> contents unchanged, drop_count=255, state FROZEN; freeze release at fill=16 -> FULL.
REQ-038 SHALL cover hist_clear and sample_valid asserted in the same cycle at fill=5 -> fill_count=0, all slots 0, drop_count=0, EMPTY, history_valid=0.
REQ-039 SHALL cover rst asserted mid-fill at fill=7 -> all outputs at reset values on the next cycle, then the next push gives fill_count=1.

Source files
------------

// File: rtl/xenoa_history_tracker.sv
// xenoa_history_tracker
// Sixteen-deep sample history with a running window sum, fill tracking,
// freeze/clear control and a saturating count of samples dropped while frozen.
// Slot [0] holds the newest sample. Slots at index >= fill_count always read zero.
module xenoa_history_tracker #(
  parameter int MIN_VALID = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sample_value,
  input  logic        sample_valid,
  input  logic        hist_clear,
  input  logic        hist_freeze,
  output logic [31:0] history_buffer [0:15],
  output logic        history_valid,
  output logic [4:0]  fill_count,
  output logic [35:0] window_sum,
  output logic [7:0]  drop_count,
  output logic [1:0]  hist_state
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FILL   = 2'd1,
    ST_FULL   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  localparam logic [4:0] DEPTH       = 5'd16;
  localparam logic [4:0] MIN_VALID_W = 5'(MIN_VALID);

  state_t      state_q, state_d;
  logic [31:0] buf_q [16];
  logic [31:0] buf_d [16];
  logic [4:0]  fill_q, fill_d;
  logic [35:0] sum_q, sum_d;
  logic [7:0]  drop_q, drop_d;
  logic        valid_q, valid_d;

  // Next-state computation: clear beats freeze, freeze beats push.
  always_comb begin
    // NOTE: every _d signal gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    drop_d  = drop_q;

    if (hist_clear) begin
      // Incoming sample is discarded and not counted as a drop.
      for (int i = 0; i < 16; i++) buf_d[i] = '0;
      fill_d  = '0;
      sum_d   = '0;
      drop_d  = '0;
      state_d = ST_EMPTY;
    end else if (hist_freeze || state_q == ST_FROZEN) begin
      // Contents held; any offered sample is dropped and counted.
      if (sample_valid && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      if (hist_freeze)              state_d = ST_FROZEN;
      else if (fill_q == '0)        state_d = ST_EMPTY;
      else if (fill_q == DEPTH)     state_d = ST_FULL;
      else                          state_d = ST_FILL;
    end else if (sample_valid) begin
      // Shift toward [15]; the retiring [15] is zero until the window is full,
      // so subtracting it is always correct.
      for (int i = 15; i > 0; i--) buf_d[i] = buf_q[i-1];
      buf_d[0] = sample_value;
      fill_d   = (fill_q == DEPTH) ? DEPTH : fill_q + 5'd1;
      sum_d    = sum_q + 36'(sample_value) - 36'(buf_q[15]);
      state_d  = (fill_d == DEPTH) ? ST_FULL : ST_FILL;
    end

    // Tracks the new fill level; unchanged fill while frozen means it holds.
    valid_d = (fill_d >= MIN_VALID_W);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_EMPTY;
      // NOTE: the history array is reset explicitly because empty slots must
      // read zero and feed zero into the window sum; a plain storage RAM would
      // normally be left unreset.
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    for (int i = 0; i < 16; i++) history_buffer[i] = buf_q[i];
  end

  assign history_valid = valid_q;
  assign fill_count    = fill_q;
  assign window_sum    = sum_q;
  assign drop_count    = drop_q;
  assign hist_state    = state_q;

endmodule

// File: tb/tb_xenoa_history_tracker.sv
// Testbench for xenoa_history_tracker: a reference model queues the expected
// outputs for every driven cycle and the queue is popped after the edge;
// scenario tasks add direct checks against hand-derived constants.
module tb_xenoa_history_tracker;

  localparam int MIN_VALID = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sample_value;
  logic        sample_valid;
  logic        hist_clear;
  logic        hist_freeze;
  logic [31:0] history_buffer [0:15];
  logic        history_valid;
  logic [4:0]  fill_count;
  logic [35:0] window_sum;
  logic [7:0]  drop_count;
  logic [1:0]  hist_state;

  always #5 clk = ~clk;

  xenoa_history_tracker #(.MIN_VALID(MIN_VALID)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_value   (sample_value),
    .sample_valid   (sample_valid),
    .hist_clear     (hist_clear),
    .hist_freeze    (hist_freeze),
    .history_buffer (history_buffer),
    .history_valid  (history_valid),
    .fill_count     (fill_count),
    .window_sum     (window_sum),
    .drop_count     (drop_count),
    .hist_state     (hist_state)
  );

  typedef struct packed {
    logic [15:0][31:0] bufv;
    logic [4:0]        fill;
    logic [35:0]       sum;
    logic [7:0]        drop;
    logic              valid;
    logic [1:0]        state;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [31:0] m_buf [16];
  int          m_fill;
  logic [35:0] m_sum;
  int          m_drop;
  logic        m_valid;
  logic [1:0]  m_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Advance the reference model by one clock edge of stimulus.
  task automatic model_update(input logic r, input logic v, input logic [31:0] val,
                              input logic c, input logic f);
    if (r || c) begin
      for (int i = 0; i < 16; i++) m_buf[i] = '0;
      m_fill = 0; m_sum = '0; m_drop = 0; m_state = 2'd0;
    end else if (f || m_state == 2'd3) begin
      if (v && m_drop < 255) m_drop++;
      if (f)                 m_state = 2'd3;
      else if (m_fill == 0)  m_state = 2'd0;
      else if (m_fill == 16) m_state = 2'd2;
      else                   m_state = 2'd1;
    end else if (v) begin
      m_sum = m_sum + {4'b0, val} - {4'b0, m_buf[15]};
      for (int i = 15; i > 0; i--) m_buf[i] = m_buf[i-1];
      m_buf[0] = val;
      if (m_fill < 16) m_fill++;
      m_state = (m_fill == 16) ? 2'd2 : 2'd1;
    end
    m_valid = (m_fill >= MIN_VALID);
  endtask

  // Drive one cycle, queue the expectation, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] val,
                      input logic c, input logic f);
    exp_t e;
    exp_t got;
    rst = r; sample_valid = v; sample_value = val; hist_clear = c; hist_freeze = f;
    model_update(r, v, val, c, f);
    for (int i = 0; i < 16; i++) e.bufv[i] = m_buf[i];
    e.fill = 5'(m_fill); e.sum = m_sum; e.drop = 8'(m_drop);
    e.valid = m_valid; e.state = m_state;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL sb_empty got=empty-queue exp=entry");
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < 16; i++) got.bufv[i] = history_buffer[i];
      got.fill = fill_count; got.sum = window_sum; got.drop = drop_count;
      got.valid = history_valid; got.state = hist_state;
      if (got !== e) begin
        $display("FAIL sb_cycle t=%0t fill got=%0d exp=%0d sum got=%h exp=%h drop got=%0d exp=%0d valid got=%b exp=%b state got=%0d exp=%0d buf0 got=%h exp=%h buf15 got=%h exp=%h",
                 $time, got.fill, e.fill, got.sum, e.sum, got.drop, e.drop, got.valid, e.valid,
                 got.state, e.state, got.bufv[0], e.bufv[0], got.bufv[15], e.bufv[15]);
      end else n_pass++;
    end
  endtask

  task automatic push(input logic [31:0] val);
    step(1'b0, 1'b1, val, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_checks++;
    if (fill_count !== 5'd0 || hist_state !== 2'd0 || history_valid !== 1'b0 ||
        window_sum !== 36'd0 || drop_count !== 8'd0 || history_buffer[0] !== 32'd0)
      $display("FAIL reset_state got fill=%0d state=%0d valid=%b sum=%h drop=%0d buf0=%h exp all zero",
               fill_count, hist_state, history_valid, window_sum, drop_count, history_buffer[0]);
    else n_pass++;
  endtask

  task automatic test_fill_four();
    for (int k = 1; k <= 3; k++) push(32'(k));
    n_checks++;
    if (history_valid !== 1'b0) $display("FAIL valid_before_min got=%b exp=0", history_valid);
    else n_pass++;
    push(32'd4);
    n_checks++;
    if (history_buffer[0] !== 32'd4 || history_buffer[1] !== 32'd3 ||
        history_buffer[2] !== 32'd2 || history_buffer[3] !== 32'd1 || history_buffer[4] !== 32'd0)
      $display("FAIL fill4_buffer got=%0d,%0d,%0d,%0d,%0d exp=4,3,2,1,0", history_buffer[0],
               history_buffer[1], history_buffer[2], history_buffer[3], history_buffer[4]);
    else n_pass++;
    n_checks++;
    if (fill_count !== 5'd4 || window_sum !== 36'd10 || history_valid !== 1'b1 || hist_state !== 2'd1)
      $display("FAIL fill4_status got fill=%0d sum=%0d valid=%b state=%0d exp fill=4 sum=10 valid=1 state=1",
               fill_count, window_sum, history_valid, hist_state);
    else n_pass++;
  endtask

  task automatic test_fill_full();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) push(32'(k));
    n_checks++;
    if (hist_state !== 2'd2 || fill_count !== 5'd16)
      $display("FAIL full_at16 got state=%0d fill=%0d exp state=2 fill=16", hist_state, fill_count);
    else n_pass++;
    push(32'd17);
    n_checks++;
    if (hist_state !== 2'd2 || history_buffer[0] !== 32'd17 || history_buffer[15] !== 32'd2 ||
        fill_count !== 5'd16 || window_sum !== 36'd152)
      $display("FAIL full_17 got state=%0d b0=%0d b15=%0d fill=%0d sum=%0d exp state=2 b0=17 b15=2 fill=16 sum=152",
               hist_state, history_buffer[0], history_buffer[15], fill_count, window_sum);
    else n_pass++;
  endtask

  task automatic test_sum_width();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) push(32'hFFFF_FFFF);
    n_checks++;
    if (window_sum !== 36'hF_FFFF_FFF0)
      $display("FAIL sum_max got=%h exp=FFFFFFFF0", window_sum);
    else n_pass++;
    push(32'h0);
    n_checks++;
    if (window_sum !== 36'hE_FFFF_FFF1)
      $display("FAIL sum_roll got=%h exp=EFFFFFFF1", window_sum);
    else n_pass++;
  endtask

  task automatic test_freeze();
    for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 32'(k + 1000), 1'b0, 1'b1);
    n_checks++;
    if (drop_count !== 8'd255 || hist_state !== 2'd3 || fill_count !== 5'd16 ||
        history_buffer[0] !== 32'h0 || history_buffer[1] !== 32'hFFFF_FFFF || window_sum !== 36'hE_FFFF_FFF1)
      $display("FAIL freeze_hold got drop=%0d state=%0d fill=%0d b0=%h b1=%h sum=%h exp drop=255 state=3 fill=16 b0=0 b1=FFFFFFFF sum=EFFFFFFF1",
               drop_count, hist_state, fill_count, history_buffer[0], history_buffer[1], window_sum);
    else n_pass++;
    // Release cycle: state is still FROZEN on this edge, so the sample is dropped.
    step(1'b0, 1'b1, 32'd99, 1'b0, 1'b0);
    n_checks++;
    if (hist_state !== 2'd2 || history_buffer[0] !== 32'h0 || drop_count !== 8'd255)
      $display("FAIL freeze_release got state=%0d b0=%h drop=%0d exp state=2 b0=0 drop=255",
               hist_state, history_buffer[0], drop_count);
    else n_pass++;
    push(32'd7);
    n_checks++;
    if (history_buffer[0] !== 32'd7 || history_buffer[1] !== 32'd0 || hist_state !== 2'd2)
      $display("FAIL post_release_push got b0=%0d b1=%0d state=%0d exp b0=7 b1=0 state=2",
               history_buffer[0], history_buffer[1], hist_state);
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'd5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) push(32'(10 + k));
    n_checks++;
    if (fill_count !== 5'd5 || drop_count !== 8'd3 || window_sum !== 36'd60)
      $display("FAIL pre_clear got fill=%0d drop=%0d sum=%0d exp fill=5 drop=3 sum=60",
               fill_count, drop_count, window_sum);
    else n_pass++;
    step(1'b0, 1'b1, 32'd77, 1'b1, 1'b1);
    n_checks++;
    if (fill_count !== 5'd0 || drop_count !== 8'd0 || hist_state !== 2'd0 ||
        history_valid !== 1'b0 || window_sum !== 36'd0 || history_buffer[0] !== 32'd0 ||
        history_buffer[4] !== 32'd0)
      $display("FAIL clear_prio got fill=%0d drop=%0d state=%0d valid=%b sum=%0d b0=%0d b4=%0d exp all zero",
               fill_count, drop_count, hist_state, history_valid, window_sum,
               history_buffer[0], history_buffer[4]);
    else n_pass++;
  endtask

  task automatic test_idle_hold();
    push(32'hA5A5_0001);
    push(32'hA5A5_0002);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0);
    n_checks++;
    if (fill_count !== 5'd2 || history_buffer[0] !== 32'hA5A5_0002 || window_sum !== 36'h1_4B4A_0003)
      $display("FAIL idle_hold got fill=%0d b0=%h sum=%h exp fill=2 b0=A5A50002 sum=14B4A0003",
               fill_count, history_buffer[0], window_sum);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) push(32'(100 + k));
    step(1'b1, 1'b1, 32'd55, 1'b0, 1'b0);
    n_checks++;
    if (fill_count !== 5'd0 || hist_state !== 2'd0 || history_valid !== 1'b0 ||
        window_sum !== 36'd0 || history_buffer[0] !== 32'd0 || history_buffer[6] !== 32'd0)
      $display("FAIL reset_mid got fill=%0d state=%0d valid=%b sum=%0d b0=%0d b6=%0d exp all zero",
               fill_count, hist_state, history_valid, window_sum, history_buffer[0], history_buffer[6]);
    else n_pass++;
    push(32'd42);
    n_checks++;
    if (fill_count !== 5'd1 || history_buffer[0] !== 32'd42 || history_buffer[1] !== 32'd0 || hist_state !== 2'd1)
      $display("FAIL first_push got fill=%0d b0=%0d b1=%0d state=%0d exp fill=1 b0=42 b1=0 state=1",
               fill_count, history_buffer[0], history_buffer[1], hist_state);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int k = 0; k < 20; k++) begin
      v = $urandom;
      step(1'b0, 1'b1, v, 1'b0, (k % 7) == 6);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_value = '0; hist_clear = 1'b0; hist_freeze = 1'b0;
    for (int i = 0; i < 16; i++) m_buf[i] = '0;
    m_fill = 0; m_sum = '0; m_drop = 0; m_valid = 1'b0; m_state = 2'd0;
    test_reset();
    test_fill_four();
    test_fill_full();
    test_sum_width();
    test_freeze();
    test_clear_priority();
    test_idle_hold();
    test_reset_mid_fill();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
